// File: rtl/ats_eligibility_calc.sv
`default_nettype none
// ============================================================================
// Module      : ats_eligibility_calc
// Description : Per-frame ATS token-bucket eligibility-time calculator.
//               Passes the ingress frame stream through, counts bytes per
//               frame, and emits one eligibility timestamp per frame
//               (0 = discard) on a separate stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ats_eligibility_calc #(
   parameter int C_AXIS_TDATA_WIDTH = 8,
   parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
   parameter int TIMESTAMP_WIDTH    = 72,
   parameter int LENGTH_WIDTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,

   input  logic [TIMESTAMP_WIDTH-1:0]    cur_time,
   input  logic [15:0]                   cfg_time_per_byte,
   input  logic [TIMESTAMP_WIDTH-1:0]    cfg_empty_to_full,
   input  logic [TIMESTAMP_WIDTH-1:0]    cfg_max_residence,

   input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tlast,

   output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,

   output logic [TIMESTAMP_WIDTH-1:0]    m_axis_timestamp_tdata,
   output logic                          m_axis_timestamp_tvalid,
   input  logic                          m_axis_timestamp_tready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_EVAL = 2'd2;
   localparam logic [1:0] ST_PUSH = 2'd3;

   localparam int CNT_W  = $clog2(C_AXIS_TKEEP_WIDTH + 1);
   localparam int PROD_W = LENGTH_WIDTH + 16;

   // Calculation state machine
   logic [1:0]                 state_q, state_d;

   // Ingress frame tracking
   logic                       first_q, first_d;
   logic [LENGTH_WIDTH-1:0]    len_q, len_d;
   logic [TIMESTAMP_WIDTH-1:0] arr_q, arr_d;

   // Per-frame operands captured at tlast acceptance
   logic [LENGTH_WIDTH-1:0]    l_lat_q, l_lat_d;
   logic [TIMESTAMP_WIDTH-1:0] a_lat_q, a_lat_d;
   logic [15:0]                tpb_q, tpb_d;
   logic [TIMESTAMP_WIDTH-1:0] e2f_q, e2f_d;
   logic [TIMESTAMP_WIDTH-1:0] maxres_q, maxres_d;

   // Pipeline intermediates
   logic [TIMESTAMP_WIDTH-1:0] lrd_q, lrd_d;
   logic [TIMESTAMP_WIDTH-1:0] set_q, set_d;
   logic [TIMESTAMP_WIDTH-1:0] bft_q, bft_d;
   logic [TIMESTAMP_WIDTH-1:0] et_q, et_d;
   logic                       ok_q, ok_d;

   // Bucket state
   logic [TIMESTAMP_WIDTH-1:0] bet_q, bet_d;
   logic [TIMESTAMP_WIDTH-1:0] get_q, get_d;

   // Timestamp output register
   logic                       ts_valid_q, ts_valid_d;
   logic [TIMESTAMP_WIDTH-1:0] ts_data_q, ts_data_d;

   // Combinational helpers
   logic                       busy;
   logic                       stall;
   logic                       beat_acc;
   logic                       last_acc;
   logic [CNT_W-1:0]           keep_cnt;
   logic [LENGTH_WIDTH:0]      len_sum;
   logic [LENGTH_WIDTH-1:0]    len_new;
   logic [TIMESTAMP_WIDTH-1:0] a_cur;
   logic [PROD_W-1:0]          product;
   logic [TIMESTAMP_WIDTH-1:0] set_w;
   logic [TIMESTAMP_WIDTH-1:0] bft_w;
   logic [TIMESTAMP_WIDTH-1:0] et_w;
   logic [TIMESTAMP_WIDTH-1:0] deadline_w;

   // Only a last beat can stall: the body of the next frame keeps flowing
   // into the downstream FIFO while a previous result is still pending.
   assign busy     = (state_q != ST_IDLE) | ts_valid_q;
   assign stall    = s_axis_tvalid & s_axis_tlast & busy;
   assign beat_acc = s_axis_tvalid & s_axis_tready;
   assign last_acc = beat_acc & s_axis_tlast;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = s_axis_tvalid & ~stall;
   assign s_axis_tready = m_axis_tready & ~stall;

   assign m_axis_timestamp_tdata  = ts_data_q;
   assign m_axis_timestamp_tvalid = ts_valid_q;

   // Count valid bytes on the current beat
   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
         keep_cnt = keep_cnt + CNT_W'(s_axis_tkeep[i]);
      end
   end

   // Track arrival time and saturating byte count; capture operands at tlast
   always_comb begin
      first_d  = first_q;
      len_d    = len_q;
      arr_d    = arr_q;
      l_lat_d  = l_lat_q;
      a_lat_d  = a_lat_q;
      tpb_d    = tpb_q;
      e2f_d    = e2f_q;
      maxres_d = maxres_q;

      a_cur    = first_q ? cur_time : arr_q;
      len_sum  = {1'b0, len_q} + (LENGTH_WIDTH + 1)'(keep_cnt);
      len_new  = len_sum[LENGTH_WIDTH] ? {LENGTH_WIDTH{1'b1}} : len_sum[LENGTH_WIDTH-1:0];

      if (beat_acc) begin
         if (s_axis_tlast) begin
            l_lat_d  = len_new;
            a_lat_d  = a_cur;
            tpb_d    = cfg_time_per_byte;
            e2f_d    = cfg_empty_to_full;
            maxres_d = cfg_max_residence;
            len_d    = '0;
            first_d  = 1'b1;
         end else begin
            len_d    = len_new;
            arr_d    = a_cur;
            first_d  = 1'b0;
         end
      end
   end

   // Next-state logic: fixed three-step calculation after each accepted tlast
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (last_acc) state_d = ST_MUL;
         ST_MUL:  state_d = ST_EVAL;
         ST_EVAL: state_d = ST_PUSH;
         ST_PUSH: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-state datapath: product, eligibility evaluation, bucket update
   always_comb begin
      lrd_d      = lrd_q;
      set_d      = set_q;
      bft_d      = bft_q;
      et_d       = et_q;
      ok_d       = ok_q;
      bet_d      = bet_q;
      get_d      = get_q;
      ts_valid_d = ts_valid_q;
      ts_data_d  = ts_data_q;

      product    = {{16{1'b0}}, l_lat_q} * {{LENGTH_WIDTH{1'b0}}, tpb_q};
      set_w      = bet_q + lrd_q;
      bft_w      = bet_q + e2f_q;
      deadline_w = a_lat_q + maxres_q;
      et_w       = a_lat_q;
      if (get_q > et_w) et_w = get_q;
      if (set_w > et_w) et_w = set_w;

      if (ts_valid_q && m_axis_timestamp_tready) begin
         ts_valid_d = 1'b0;
      end

      case (state_q)
         ST_MUL: begin
            lrd_d = TIMESTAMP_WIDTH'(product);
         end
         ST_EVAL: begin
            set_d = set_w;
            bft_d = bft_w;
            et_d  = et_w;
            ok_d  = (et_w <= deadline_w);
         end
         ST_PUSH: begin
            // A rejected frame leaves the bucket untouched
            if (ok_q) begin
               get_d = et_q;
               bet_d = (et_q < bft_q) ? set_q : (set_q + et_q - bft_q);
            end
            // 0 is reserved for "discard", so an eligible time of 0 becomes 1
            if (!ok_q)
               ts_data_d = '0;
            else if (et_q == '0)
               ts_data_d = TIMESTAMP_WIDTH'(1);
            else
               ts_data_d = et_q;
            ts_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         first_q    <= 1'b1;
         len_q      <= '0;
         arr_q      <= '0;
         l_lat_q    <= '0;
         a_lat_q    <= '0;
         tpb_q      <= '0;
         e2f_q      <= '0;
         maxres_q   <= '0;
         lrd_q      <= '0;
         set_q      <= '0;
         bft_q      <= '0;
         et_q       <= '0;
         ok_q       <= 1'b0;
         bet_q      <= '0;
         get_q      <= '0;
         ts_valid_q <= 1'b0;
         ts_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         len_q      <= len_d;
         arr_q      <= arr_d;
         l_lat_q    <= l_lat_d;
         a_lat_q    <= a_lat_d;
         tpb_q      <= tpb_d;
         e2f_q      <= e2f_d;
         maxres_q   <= maxres_d;
         lrd_q      <= lrd_d;
         set_q      <= set_d;
         bft_q      <= bft_d;
         et_q       <= et_d;
         ok_q       <= ok_d;
         bet_q      <= bet_d;
         get_q      <= get_d;
         ts_valid_q <= ts_valid_d;
         ts_data_q  <= ts_data_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ats_eligibility_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ats_eligibility_calc
// Description : Self-checking bench for ats_eligibility_calc. A frame-level
//               token-bucket model predicts every timestamp and the frame
//               path gating; directed scenarios pin known results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ats_eligibility_calc;

   localparam int TW = 72;

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] cur_time;
   logic [15:0]   cfg_tpb;
   logic [TW-1:0] cfg_e2f;
   logic [TW-1:0] cfg_maxres;
   logic [7:0]    s_tdata;
   logic [0:0]    s_tkeep;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic [7:0]    m_tdata;
   logic [0:0]    m_tkeep;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic [TW-1:0] ts_tdata;
   logic          ts_tvalid;
   logic          ts_tready;

   always #5 clk = ~clk;

   ats_eligibility_calc dut (
      .clk                     (clk),
      .rst                     (rst),
      .cur_time                (cur_time),
      .cfg_time_per_byte       (cfg_tpb),
      .cfg_empty_to_full       (cfg_e2f),
      .cfg_max_residence       (cfg_maxres),
      .s_axis_tdata            (s_tdata),
      .s_axis_tkeep            (s_tkeep),
      .s_axis_tvalid           (s_tvalid),
      .s_axis_tready           (s_tready),
      .s_axis_tlast            (s_tlast),
      .m_axis_tdata            (m_tdata),
      .m_axis_tkeep            (m_tkeep),
      .m_axis_tvalid           (m_tvalid),
      .m_axis_tready           (m_tready),
      .m_axis_tlast            (m_tlast),
      .m_axis_timestamp_tdata  (ts_tdata),
      .m_axis_timestamp_tvalid (ts_tvalid),
      .m_axis_timestamp_tready (ts_tready)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
      end
   endtask

   // Frame-level model: bucket state, frame accumulation, pending result
   logic [TW-1:0] m_bet, m_get, m_a, m_res, m_ts;
   int            m_len;
   int            m_cnt;
   logic          m_tv;
   logic          m_first;

   initial begin
      m_bet = '0; m_get = '0; m_a = '0; m_res = '0; m_ts = '0;
      m_len = 0; m_cnt = 0; m_tv = 1'b0; m_first = 1'b1;
   end

   // Compare on the falling edge, then advance the model to the next rising edge
   always @(negedge clk) begin : p_cmp
      logic          exp_stall;
      logic          acc;
      logic [TW-1:0] lrd, set_t, bft, et;
      exp_stall = s_tvalid & s_tlast & ((m_cnt != 0) | m_tv);
      if (chk_en) begin
         chk1("ts_tvalid", ts_tvalid, m_tv);
         if (m_tv) chk("ts_tdata", ts_tdata, m_ts);
         chk1("m_tvalid", m_tvalid, s_tvalid & ~exp_stall);
         chk1("s_tready", s_tready, m_tready & ~exp_stall);
         chk("m_tdata", TW'(m_tdata), TW'(s_tdata));
         chk1("m_tlast", m_tlast, s_tlast);
         chk1("m_tkeep", m_tkeep[0], s_tkeep[0]);
      end
      acc = s_tvalid & m_tready & ~exp_stall;
      if (rst) begin
         m_bet = '0; m_get = '0; m_len = 0; m_cnt = 0; m_tv = 1'b0; m_first = 1'b1;
      end else begin
         if (m_tv && ts_tready) m_tv = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_tv = 1'b1;
               m_ts = m_res;
            end
         end
         if (acc) begin
            if (m_first) m_a = cur_time;
            m_first = 1'b0;
            m_len = m_len + $countones(s_tkeep);
            if (m_len > 65535) m_len = 65535;
            if (s_tlast) begin
               lrd   = TW'(m_len) * TW'(cfg_tpb);
               set_t = m_bet + lrd;
               bft   = m_bet + cfg_e2f;
               et    = m_a;
               if (m_get > et) et = m_get;
               if (set_t > et) et = set_t;
               if (et <= m_a + cfg_maxres) begin
                  m_res = (et == '0) ? TW'(1) : et;
                  m_get = et;
                  m_bet = (et < bft) ? set_t : (set_t + et - bft);
               end else begin
                  m_res = '0;
               end
               m_cnt   = 3;
               m_len   = 0;
               m_first = 1'b1;
            end
         end
      end
   end

   // Send an n-byte frame; the arrival time is presented only for the first
   // beat, after which cur_time jumps so a late latch would be visible.
   task automatic send_frame(input int n, input logic [TW-1:0] a);
      bit acc;
      cur_time = a;
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'((i * 7 + n) & 255);
         s_tkeep  = 1'b1;
         s_tlast  = (i == n - 1);
         acc = 1'b0;
         for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
         end
         if (!acc) chk1("beat_accept_timeout", s_tready, 1'b1);
         if (i == 0) cur_time = a + TW'(5000);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Wait (bounded) for a timestamp, compare with a literal, consume it
   task automatic wait_ts(input logic [TW-1:0] exp, input string nm, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      for (int t = 1; t <= 200 && !got; t++) begin
         @(negedge clk);
         if (ts_tvalid) begin
            got = 1'b1;
            lat = t;
         end
      end
      if (!got) chk1({nm, "_timeout"}, ts_tvalid, 1'b1);
      else      chk(nm, ts_tdata, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : p_watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      int lat;
      int cnt;
      rst = 1'b1; cur_time = '0;
      cfg_tpb = 16'd8; cfg_e2f = TW'(1000); cfg_maxres = TW'(10000);
      s_tdata = '0; s_tkeep = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
      m_tready = 1'b1; ts_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      chk1("reset_ts_tvalid", ts_tvalid, 1'b0);
      chk("reset_ts_tdata", ts_tdata, TW'(0));
      @(posedge clk);
      #1;

      // Single frame: 64*8 = 512, four cycles after tlast
      send_frame(64, TW'(100));
      wait_ts(TW'(512), "single_ts", lat);
      chk("single_latency", TW'(lat), TW'(4));
      chk("single_model_bet", m_bet, TW'(512));
      chk("single_model_get", m_get, TW'(512));

      // Back-to-back: SET = 512 + 512
      send_frame(64, TW'(200));
      wait_ts(TW'(1024), "b2b_ts", lat);
      chk("b2b_model_bet", m_bet, TW'(1024));

      // Discard: 1024 > 200 + 500, bucket untouched for the third frame
      do_reset();
      send_frame(64, TW'(100));
      wait_ts(TW'(512), "disc_first_ts", lat);
      cfg_maxres = TW'(500);
      send_frame(64, TW'(200));
      wait_ts(TW'(0), "disc_ts", lat);
      chk("disc_model_bet", m_bet, TW'(512));
      cfg_maxres = TW'(10000);
      send_frame(64, TW'(200));
      wait_ts(TW'(1024), "disc_third_ts", lat);

      // Idle refill: BET = 1024 + 10000 - 1512
      do_reset();
      send_frame(64, TW'(100));
      wait_ts(TW'(512), "refill_first_ts", lat);
      send_frame(64, TW'(10000));
      wait_ts(TW'(10000), "refill_ts", lat);
      chk("refill_model_bet", m_bet, TW'(9512));

      // Backpressure on the timestamp stream stalls only the next last beat
      do_reset();
      ts_tready = 1'b0;
      send_frame(64, TW'(100));
      fork
         send_frame(64, TW'(200));
         begin
            repeat (90) @(posedge clk);
            @(negedge clk);
            chk1("bp_ts_held", ts_tvalid, 1'b1);
            chk("bp_ts_data", ts_tdata, TW'(512));
            chk1("bp_at_last_beat", s_tlast, 1'b1);
            chk1("bp_last_stalled", s_tready, 1'b0);
            @(posedge clk);
            #1;
            ts_tready = 1'b1;
         end
      join
      wait_ts(TW'(1024), "bp_second_ts", lat);

      // Single-beat frame: L = 1, ET = A = 300
      do_reset();
      send_frame(1, TW'(300));
      wait_ts(TW'(300), "single_beat_ts", lat);

      // Zero mapping: tpb = 0, A = 0 gives ET = 0 reported as 1
      do_reset();
      cfg_tpb = 16'd0;
      send_frame(4, TW'(0));
      wait_ts(TW'(1), "zero_map_ts", lat);
      cfg_tpb = 16'd8;

      // Reset while in EVAL drops the result and the bucket state
      do_reset();
      send_frame(64, TW'(100));
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ts_tvalid) cnt++;
      end
      chk("rst_eval_no_ts", TW'(cnt), TW'(0));
      @(posedge clk);
      #1;
      send_frame(64, TW'(100));
      wait_ts(TW'(512), "post_rst_ts", lat);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ats_eligibility_calc.md
# ats_eligibility_calc

Per-frame ATS (IEEE 802.1Qcr token-bucket) eligibility-time calculator on the ingress path. It sits directly upstream of `connect_timestamp` and its frame FIFO. It passes the frame stream through unchanged and counts bytes per frame. At end of frame it computes the eligibility time and emits it on a timestamp stream. The value 0 on that stream means "discard"; `connect_timestamp` consumes it with that meaning.

## Interface
- `C_AXIS_TDATA_WIDTH`, default 8: frame data width.
- `C_AXIS_TKEEP_WIDTH`, default `C_AXIS_TDATA_WIDTH/8`: keep width.
- `TIMESTAMP_WIDTH`, default 72: width of all time values.
- `LENGTH_WIDTH`, default 16: byte-counter width.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cur_time` in `TIMESTAMP_WIDTH`: free-running scheduler timer.
- `cfg_time_per_byte` in 16: timer ticks per byte (committed rate).
- `cfg_empty_to_full` in `TIMESTAMP_WIDTH`: bucket empty-to-full duration.
- `cfg_max_residence` in `TIMESTAMP_WIDTH`: maximum residence time.
- `s_axis_tdata`/`tkeep`/`tvalid`/`tready`/`tlast`: in/in/in/out/in; frame input.
- `m_axis_tdata`/`tkeep`/`tvalid`/`tready`/`tlast`: out/out/out/in/out; frame output to the frame FIFO.
- `m_axis_timestamp_tdata` out `TIMESTAMP_WIDTH`: eligibility time, or 0 for discard.
- `m_axis_timestamp_tvalid` out 1, `m_axis_timestamp_tready` in 1.

## Operation
- Frame path is combinational.
  - `m_axis_tdata`/`tkeep`/`tlast` = the `s_axis` equivalents.
  - `m_axis_tvalid = s_axis_tvalid & ~stall`.
  - `s_axis_tready = m_axis_tready & ~stall`.
  - `stall = s_axis_tvalid & s_axis_tlast & busy`.
  - `busy = (state != IDLE) | ts_valid`.
  - Only a last beat is ever stalled.
- Arrival time `A`: `cur_time` latched on the first accepted beat of each frame. A `first` flag is set at reset and after each accepted tlast.
- Length `L`: sum of popcount(`tkeep`) over accepted beats, including the last beat. It saturates at 2^`LENGTH_WIDTH`-1 and is cleared after tlast.
- On tlast acceptance, latch `L`, `A` and the three cfg inputs, then go to `MUL`.
- State machine:
  - `IDLE`: wait for tlast acceptance.
  - `MUL`: `LRD = L * cfg_time_per_byte`, zero-extended to `TIMESTAMP_WIDTH`.
  - `EVAL`:
    - `SET = BET + LRD`
    - `BFT = BET + cfg_empty_to_full`
    - `ET = max(A, GET, SET)`
    - `ok = (ET <= A + cfg_max_residence)`
  - `PUSH`:
    - If `ok`: `GET <= ET`.
    - If `ok` and `ET < BFT`: `BET <= SET`.
    - If `ok` and `ET >= BFT`: `BET <= SET + ET - BFT`.
    - Load the output register with `ok ? (ET==0 ? 1 : ET) : 0`, set `ts_valid`, go to `IDLE`.
    - If not `ok`, `BET` and `GET` are unchanged.
- Output register: `ts_valid` drives `m_axis_timestamp_tvalid`. It is cleared on the `m_axis_timestamp` handshake.
- Arithmetic: unsigned, modulo 2^`TIMESTAMP_WIDTH`. Comparisons are plain unsigned; the timer never wraps in service.
- Deadlock freedom: at most one timestamp is pending. The next frame's body still flows, so the downstream frame FIFO must hold at least one maximum-size frame.

## Timing
- Reset values:
  - `state = IDLE`; `BET = GET = 0`; `ts_valid = 0`; `L = 0`; `first = 1`.
  - `m_axis_timestamp_tdata = 0`; `m_axis_timestamp_tvalid = 0`.
  - Frame outputs follow the inputs, with `tvalid`/`tready` gated as above.
- Latency, tlast accepted in cycle N:
  - `MUL` in N+1, `EVAL` in N+2, `PUSH` in N+3.
  - `m_axis_timestamp_tvalid` is high from N+4 until the handshake.
- A new frame's last beat arriving while `busy` is held: `s_axis_tready = 0` until `state == IDLE` and `ts_valid == 0`. The earliest acceptance is the cycle after the timestamp handshake.
- Simultaneous handshake: a timestamp handshake in the same cycle as `PUSH` cannot occur, because `ts_valid` is already 0 at `PUSH`.
- Single-beat frame: `A` and `L` are taken from that one beat.
- cfg changes mid-frame take effect only if present at tlast acceptance.
- Reset mid-calculation or mid-frame:
  - The pending result and the partial counters are dropped.
  - Bucket state returns to 0.
  - The following beat is treated as the first beat of a frame.

## Test plan
- Reset: assert `rst` for 2 cycles -> `m_axis_timestamp_tvalid = 0`, `tdata = 0`; first frame sees `BET = GET = 0`.
- Single frame: 64 bytes, `tpb = 8`, `e2f = 1000`, `maxres = 10000`, `A = 100` -> timestamp 512 at tlast+4; `BET = 512`, `GET = 512`; frame bytes identical at output.
- Back-to-back: second 64-byte frame with `A = 200` -> `SET = 1024`, `ET = 1024`, output 1024.
- Discard: same as the back-to-back case but `maxres = 500` -> 1024 > 700, so output 0; `BET` and `GET` unchanged, so a third frame computes `SET = 1024`.
- Idle refill: after the single-frame case, 64-byte frame with `A = 10000` -> output 10000; `BET = 1024 + 10000 - 1512 = 9512`.
- Backpressure, zero mapping and reset:
  - Hold `m_axis_timestamp_tready` low -> the second frame body passes and its last beat stalls until the handshake.
  - `tpb = 0`, `A = 0` -> output 1.
  - `rst` during `EVAL` -> no timestamp emitted.
